// File: rtl/router_pkg.sv
// Shared mesh-router definitions: port directions, port indices and the
// output-arbiter state encoding, plus small index helpers.
package router_pkg;

  localparam int NUM_PORTS = 5;

  localparam int IDX_L  = 4;
  localparam int IDX_R  = 3;
  localparam int IDX_U  = 2;
  localparam int IDX_D  = 1;
  localparam int IDX_PE = 0;

  localparam logic [NUM_PORTS-1:0] DIR_L  = 5'b10000;
  localparam logic [NUM_PORTS-1:0] DIR_R  = 5'b01000;
  localparam logic [NUM_PORTS-1:0] DIR_U  = 5'b00100;
  localparam logic [NUM_PORTS-1:0] DIR_D  = 5'b00010;
  localparam logic [NUM_PORTS-1:0] DIR_PE = 5'b00001;

  // Index value returned for anything that is not a legal one-hot direction.
  localparam logic [2:0] IDX_NONE = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_CLEAR = 2'd2
  } arb_state_t;

  function automatic logic [2:0] dir_to_idx(input logic [NUM_PORTS-1:0] dir);
    case (dir)
      DIR_L:   return 3'(IDX_L);
      DIR_R:   return 3'(IDX_R);
      DIR_U:   return 3'(IDX_U);
      DIR_D:   return 3'(IDX_D);
      DIR_PE:  return 3'(IDX_PE);
      default: return IDX_NONE;
    endcase
  endfunction

  // Round-robin successor: L wraps back to PE.
  function automatic logic [2:0] ptr_after(input logic [2:0] idx);
    return (idx >= 3'(IDX_L)) ? 3'(IDX_PE) : idx + 3'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick over the five router ports: the search starts
// at the pointer index, ascends, wraps L->PE, and the first set request wins.
module rr_arbiter
  import router_pkg::*;
(
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [2:0]           i_ptr,
  output logic [NUM_PORTS-1:0] o_grant,
  output logic [2:0]           o_idx,
  output logic                 o_valid
);

  logic [2:0] w_start;
  logic [3:0] w_pos;

  // NOTE: every combinational output gets a default before the search loop so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_pos   = '0;
    // An out-of-range pointer falls back to PE rather than skipping ports.
    w_start = (i_ptr < 3'(NUM_PORTS)) ? i_ptr : 3'(IDX_PE);
    for (int off = 0; off < NUM_PORTS; off++) begin
      w_pos = {1'b0, w_start} + 4'(off);
      if (w_pos >= 4'(NUM_PORTS)) begin
        w_pos = w_pos - 4'(NUM_PORTS);
      end
      if (!o_valid && i_req[w_pos[2:0]]) begin
        o_valid             = 1'b1;
        o_grant[w_pos[2:0]] = 1'b1;
        o_idx               = w_pos[2:0];
      end
    end
  end

endmodule

// File: rtl/output_arbiter.sv
// Per-output-port controller: round-robin selects one of five routed inputs,
// registers its flit, runs the send/ready handshake and pulses the winner's clr.
module output_arbiter
  import router_pkg::*;
#(
  parameter int                   DATA_WIDTH    = 64,
  parameter logic [NUM_PORTS-1:0] OUT_DIRECTION = DIR_PE,
  parameter logic [NUM_PORTS-1:0] PORT_MASK     = 5'b11111
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            req,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] datai,
  input  logic                            ro,
  output logic                            so,
  output logic [DATA_WIDTH-1:0]           datao,
  output logic [NUM_PORTS-1:0]            clr,
  output logic [NUM_PORTS-1:0]            grant
);

  arb_state_t            r_state;
  arb_state_t            w_next_state;
  logic [2:0]            r_ptr;
  logic [2:0]            r_idx;
  logic [NUM_PORTS-1:0]  r_grant;
  logic [DATA_WIDTH-1:0] r_datao;

  logic [NUM_PORTS-1:0]  w_ereq;
  logic [NUM_PORTS-1:0]  w_win;
  logic [2:0]            w_win_idx;
  logic                  w_win_valid;
  logic [DATA_WIDTH-1:0] w_win_data;
  logic                  w_load;
  logic                  w_release;

  // Masked inputs (e.g. the U-turn port) never reach the arbiter.
  assign w_ereq = req & PORT_MASK;

  rr_arbiter u_rr (
    .i_req   (w_ereq),
    .i_ptr   (r_ptr),
    .o_grant (w_win),
    .o_idx   (w_win_idx),
    .o_valid (w_win_valid)
  );

  always_comb begin
    w_win_data = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (w_win[k]) begin
        w_win_data = w_win_data | datai[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_release    = 1'b0;
    so           = 1'b0;
    clr          = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_win_valid) begin
          w_load       = 1'b1;
          w_next_state = ST_SEND;
        end
      end
      ST_SEND: begin
        so = 1'b1;
        if (ro) begin
          w_next_state = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        clr          = r_grant;
        w_release    = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // NOTE: the flit register is reset like the control state, so a reset in the
  // middle of a packet drops the latched flit and datao reads zero afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr   <= 3'(IDX_PE);
      r_idx   <= 3'(IDX_PE);
      r_grant <= '0;
      r_datao <= '0;
    end else if (w_load) begin
      r_grant <= w_win;
      r_idx   <= w_win_idx;
      r_datao <= w_win_data;
    end else if (w_release) begin
      r_grant <= '0;
      r_ptr   <= ptr_after(r_idx);
    end
  end

  assign grant = r_grant;
  assign datao = r_datao;

  a_out_dir_onehot: assert property (@(posedge clk) disable iff (!rst)
    dir_to_idx(OUT_DIRECTION) != IDX_NONE);

  a_clr_onehot0: assert property (@(posedge clk) disable iff (!rst)
    $onehot0(clr));

endmodule

// File: tb/tb_output_arbiter.sv
// Directed bench for output_arbiter: one task per scenario, hand-computed
// expectations for the {so, grant, clr} control bundle and the flit.
module tb_output_arbiter;

  localparam int DW = 64;

  logic            clk;
  logic            rst;
  logic [4:0]      req;
  logic [5*DW-1:0] datai;
  logic            ro;
  logic            so;
  logic [DW-1:0]   datao;
  logic [4:0]      clr;
  logic [4:0]      grant;

  logic [4:0]      m_req;
  logic [5*DW-1:0] m_datai;
  logic            m_ro;
  logic            m_so;
  logic [DW-1:0]   m_datao;
  logic [4:0]      m_clr;
  logic [4:0]      m_grant;

  int errors = 0;
  int checks = 0;

  logic [10:0] exp_ctl;

  output_arbiter #(.DATA_WIDTH(DW), .OUT_DIRECTION(5'b00001), .PORT_MASK(5'b11111)) u_dut (
    .clk(clk), .rst(rst), .req(req), .datai(datai), .ro(ro),
    .so(so), .datao(datao), .clr(clr), .grant(grant)
  );

  output_arbiter #(.DATA_WIDTH(DW), .OUT_DIRECTION(5'b00100), .PORT_MASK(5'b11011)) u_mask (
    .clk(clk), .rst(rst), .req(m_req), .datai(m_datai), .ro(m_ro),
    .so(m_so), .datao(m_datao), .clr(m_clr), .grant(m_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0; req = '0; datai = '0; ro = 1'b0;
    m_req = '0; m_datai = '0; m_ro = 1'b0;
    #1;
    exp_ctl = 11'b0;
    if ({so, grant, clr} !== exp_ctl) begin
      errors++; $display("FAIL reset_ctl: so_grant_clr=%b expected %b", {so, grant, clr}, exp_ctl);
    end
    checks++;
    if (datao !== 64'h0) begin
      errors++; $display("FAIL reset_datao: got %h expected %h", datao, 64'h0);
    end
    checks++;
    if ({m_so, m_grant, m_clr} !== exp_ctl) begin
      errors++; $display("FAIL reset_mask_ctl: so_grant_clr=%b expected %b", {m_so, m_grant, m_clr}, exp_ctl);
    end
    checks++;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_single;
    do_reset();
    datai[0 +: DW] = 64'hA5; req = 5'b00001; ro = 1'b1;
    tick();
    exp_ctl = {1'b1, 5'b00001, 5'b00000};
    if ({so, grant, clr} !== exp_ctl) begin
      errors++; $display("FAIL single_send: so_grant_clr=%b expected %b", {so, grant, clr}, exp_ctl);
    end
    checks++;
    if (datao !== 64'hA5) begin
      errors++; $display("FAIL single_datao: got %h expected %h", datao, 64'hA5);
    end
    checks++;
    tick();
    exp_ctl = {1'b0, 5'b00001, 5'b00001};
    if ({so, grant, clr} !== exp_ctl) begin
      errors++; $display("FAIL single_clear: so_grant_clr=%b expected %b", {so, grant, clr}, exp_ctl);
    end
    checks++;
    req = '0;
    tick();
    exp_ctl = 11'b0;
    if ({so, grant, clr} !== exp_ctl) begin
      errors++; $display("FAIL single_idle: so_grant_clr=%b expected %b", {so, grant, clr}, exp_ctl);
    end
    checks++;
    // Pointer now 1: with PE and D both requesting, D must win.
    datai[1*DW +: DW] = 64'hD1; req = 5'b00011;
    tick();
    exp_ctl = {1'b1, 5'b00010, 5'b00000};
    if ({so, grant, clr} !== exp_ctl) begin
      errors++; $display("FAIL single_ptr_next: so_grant_clr=%b expected %b", {so, grant, clr}, exp_ctl);
    end
    checks++;
    if (datao !== 64'hD1) begin
      errors++; $display("FAIL single_ptr_datao: got %h expected %h", datao, 64'hD1);
    end
    checks++;
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_all_five;
    int order [6] = '{0, 1, 2, 3, 4, 0};
    logic [4:0] oh;
    do_reset();
    for (int k = 0; k < 5; k++) datai[k*DW +: DW] = 64'h100 + 64'(k);
    req = 5'b11111; ro = 1'b1;
    for (int j = 0; j < 6; j++) begin
      oh = 5'b00001 << order[j];
      tick();
      exp_ctl = {1'b1, oh, 5'b00000};
      if ({so, grant, clr} !== exp_ctl) begin
        errors++; $display("FAIL rr_send[%0d]: so_grant_clr=%b expected %b", j, {so, grant, clr}, exp_ctl);
      end
      checks++;
      if (datao !== 64'h100 + 64'(order[j])) begin
        errors++; $display("FAIL rr_datao[%0d]: got %h expected %h", j, datao, 64'h100 + 64'(order[j]));
      end
      checks++;
      tick();
      exp_ctl = {1'b0, oh, oh};
      if ({so, grant, clr} !== exp_ctl) begin
        errors++; $display("FAIL rr_clear[%0d]: so_grant_clr=%b expected %b", j, {so, grant, clr}, exp_ctl);
      end
      checks++;
      if (j == 5) req = '0;
      tick();
      exp_ctl = 11'b0;
      if ({so, grant, clr} !== exp_ctl) begin
        errors++; $display("FAIL rr_idle[%0d]: so_grant_clr=%b expected %b", j, {so, grant, clr}, exp_ctl);
      end
      checks++;
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    datai = '0; datai[2*DW +: DW] = 64'hC0FFEE; req = 5'b00100; ro = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      exp_ctl = {1'b1, 5'b00100, 5'b00000};
      if ({so, grant, clr} !== exp_ctl) begin
        errors++; $display("FAIL bp_hold[%0d]: so_grant_clr=%b expected %b", i, {so, grant, clr}, exp_ctl);
      end
      checks++;
      if (datao !== 64'hC0FFEE) begin
        errors++; $display("FAIL bp_datao[%0d]: got %h expected %h", i, datao, 64'hC0FFEE);
      end
      checks++;
      datai[2*DW +: DW] = 64'hBAD0 + 64'(i);
      req = (i % 2 == 0) ? 5'b10111 : 5'b00100;
      tick();
    end
    exp_ctl = {1'b1, 5'b00100, 5'b00000};
    if ({so, grant, clr} !== exp_ctl || datao !== 64'hC0FFEE) begin
      errors++; $display("FAIL bp_seventh: so_grant_clr=%b datao=%h expected %b %h", {so, grant, clr}, datao, exp_ctl, 64'hC0FFEE);
    end
    checks++;
    ro = 1'b1; req = 5'b00100;
    tick();
    exp_ctl = {1'b0, 5'b00100, 5'b00100};
    if ({so, grant, clr} !== exp_ctl) begin
      errors++; $display("FAIL bp_clear: so_grant_clr=%b expected %b", {so, grant, clr}, exp_ctl);
    end
    checks++;
    req = '0;
    tick();
    tick();
    exp_ctl = 11'b0;
    if ({so, grant, clr} !== exp_ctl) begin
      errors++; $display("FAIL bp_single_clr: so_grant_clr=%b expected %b", {so, grant, clr}, exp_ctl);
    end
    checks++;
  endtask

  task automatic test_mask;
    do_reset();
    m_datai = '0; m_datai[2*DW +: DW] = 64'hEEEE; m_datai[1*DW +: DW] = 64'hD0D0;
    m_req = 5'b00100; m_ro = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_ctl = 11'b0;
      if ({m_so, m_grant, m_clr} !== exp_ctl) begin
        errors++; $display("FAIL mask_blocked[%0d]: so_grant_clr=%b expected %b", i, {m_so, m_grant, m_clr}, exp_ctl);
      end
      checks++;
    end
    m_req = 5'b00110;
    tick();
    exp_ctl = {1'b1, 5'b00010, 5'b00000};
    if ({m_so, m_grant, m_clr} !== exp_ctl || m_datao !== 64'hD0D0) begin
      errors++; $display("FAIL mask_grant_d: so_grant_clr=%b datao=%h expected %b %h", {m_so, m_grant, m_clr}, m_datao, exp_ctl, 64'hD0D0);
    end
    checks++;
    tick();
    exp_ctl = {1'b0, 5'b00010, 5'b00010};
    if ({m_so, m_grant, m_clr} !== exp_ctl) begin
      errors++; $display("FAIL mask_clear_d: so_grant_clr=%b expected %b", {m_so, m_grant, m_clr}, exp_ctl);
    end
    checks++;
    m_req = '0; m_ro = 1'b0;
    tick();
  endtask

  task automatic test_async_reset;
    do_reset();
    datai = '0; datai[3*DW +: DW] = 64'hBEEF; req = 5'b01000; ro = 1'b0;
    tick();
    exp_ctl = {1'b1, 5'b01000, 5'b00000};
    if ({so, grant, clr} !== exp_ctl || datao !== 64'hBEEF) begin
      errors++; $display("FAIL arst_pre: so_grant_clr=%b datao=%h expected %b %h", {so, grant, clr}, datao, exp_ctl, 64'hBEEF);
    end
    checks++;
    #2;
    rst = 1'b0;
    #1;
    exp_ctl = 11'b0;
    if ({so, grant, clr} !== exp_ctl || datao !== 64'h0) begin
      errors++; $display("FAIL arst_immediate: so_grant_clr=%b datao=%h expected %b %h", {so, grant, clr}, datao, exp_ctl, 64'h0);
    end
    checks++;
    ro = 1'b1;
    tick();
    if ({so, grant, clr} !== exp_ctl) begin
      errors++; $display("FAIL arst_no_clr: so_grant_clr=%b expected %b", {so, grant, clr}, exp_ctl);
    end
    checks++;
    rst = 1'b1;
    datai[0 +: DW] = 64'hE0; req = 5'b01001;
    tick();
    exp_ctl = {1'b1, 5'b00001, 5'b00000};
    if ({so, grant, clr} !== exp_ctl || datao !== 64'hE0) begin
      errors++; $display("FAIL arst_pe_first: so_grant_clr=%b datao=%h expected %b %h", {so, grant, clr}, datao, exp_ctl, 64'hE0);
    end
    checks++;
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_withdraw;
    do_reset();
    datai = '0; datai[3*DW +: DW] = 64'h1234; req = 5'b01000; ro = 1'b0;
    tick();
    req = '0; datai = {5{64'hFFFF_0000_FFFF_0000}};
    tick();
    exp_ctl = {1'b1, 5'b01000, 5'b00000};
    if ({so, grant, clr} !== exp_ctl || datao !== 64'h1234) begin
      errors++; $display("FAIL wd_send: so_grant_clr=%b datao=%h expected %b %h", {so, grant, clr}, datao, exp_ctl, 64'h1234);
    end
    checks++;
    ro = 1'b1;
    tick();
    exp_ctl = {1'b0, 5'b01000, 5'b01000};
    if ({so, grant, clr} !== exp_ctl) begin
      errors++; $display("FAIL wd_clear: so_grant_clr=%b expected %b", {so, grant, clr}, exp_ctl);
    end
    checks++;
    tick();
    exp_ctl = 11'b0;
    if ({so, grant, clr} !== exp_ctl) begin
      errors++; $display("FAIL wd_idle: so_grant_clr=%b expected %b", {so, grant, clr}, exp_ctl);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_five();
    test_backpressure();
    test_mask();
    test_async_reset();
    test_withdraw();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
